// File: rtl/chdr_null_pattern_checker.sv
// ---------------------------------------------------------------------------
// chdr_null_pattern_checker
//
// Receive-side checker for the null source's pattern generator. It sinks a
// CHDR stream and checks every payload line against the generator pattern
// {NIPC{~i[H-1:0], i[H-1:0]}} (H = ITEM_W/2). It also checks the header
// Length field against the number of lines received and checks that SeqNum
// increments by one per checked packet. All results are exported as counters.
//
// Ports
//   rfnoc_chdr_clk     in   sole clock
//   rfnoc_chdr_rst_n   in   asynchronous active-low reset
//   enable             in   check/count packets, sampled at packet start only
//   clear              in   1-cycle pulse: zero counters, drop seq/pattern lock
//   s_axis_tdata       in   CHDR line (header in bits [63:0] of first line)
//   s_axis_tlast       in   last line of packet
//   s_axis_tvalid      in   line valid
//   s_axis_tready      out  0 during reset, then constantly 1 (pure sink)
//   pkt_cnt            out  checked packets (wraps)
//   line_cnt           out  checked payload lines (wraps)
//   pattern_err_cnt    out  payload lines with a mismatched item (saturates)
//   len_err_cnt        out  packets with Length/line-count mismatch (saturates)
//   seq_err_cnt        out  packets with a SeqNum discontinuity (saturates)
//   err_stb            out  1-cycle pulse when any error counter increments
//   locked             out  pattern index established since reset/clear
//   dbg_state_o        out  current parser state (debug visibility)
//
// Handshake: a line is transferred ("beat") on a rising clock edge where
// s_axis_tvalid and s_axis_tready are both 1; nothing else advances the
// parser. All outputs are registered and reflect a beat one cycle later.
// ---------------------------------------------------------------------------
module chdr_null_pattern_checker #(
    parameter int CHDR_W = 64,
    parameter int ITEM_W = 32,
    parameter int ERR_W  = 16
) (
    input  logic              rfnoc_chdr_clk,
    input  logic              rfnoc_chdr_rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic [CHDR_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [31:0]       pkt_cnt,
    output logic [31:0]       line_cnt,
    output logic [ERR_W-1:0]  pattern_err_cnt,
    output logic [ERR_W-1:0]  len_err_cnt,
    output logic [ERR_W-1:0]  seq_err_cnt,
    output logic              err_stb,
    output logic              locked,
    output logic [2:0]        dbg_state_o
);

    localparam int NIPC   = CHDR_W / ITEM_W;
    localparam int H      = ITEM_W / 2;
    localparam int BYTES  = CHDR_W / 8;
    localparam int LB     = $clog2(BYTES);
    localparam int IBYTES = ITEM_W / 8;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [H-1:0]     H_ONE   = {{(H-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_TS   = 3'd1,
        S_MD   = 3'd2,
        S_PYLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [LB-1:0]     len_rem_q, len_rem_d;     // Length mod line bytes
    logic [16:0]       exp_lines_q, exp_lines_d; // ceil(Length / line bytes)
    logic              short_q, short_d;         // Length below header+TS+mdata
    logic [4:0]        md_left_q, md_left_d;
    logic [16:0]       line_no_q, line_no_d;     // lines of this packet so far
    logic [15:0]       seq_prev_q, seq_prev_d;
    logic              seq_valid_q, seq_valid_d;
    logic [H-1:0]      exp_q, exp_d;
    logic              locked_q, locked_d;
    logic              tready_q;
    logic [31:0]       pkt_cnt_q, pkt_cnt_d;
    logic [31:0]       line_cnt_q, line_cnt_d;
    logic [ERR_W-1:0]  pat_cnt_q, pat_cnt_d;
    logic [ERR_W-1:0]  len_cnt_q, len_cnt_d;
    logic [ERR_W-1:0]  seq_cnt_q, seq_cnt_d;
    logic              err_stb_q, err_stb_d;

    logic              beat;
    logic [2:0]        hdr_type;
    logic [4:0]        hdr_nmd;
    logic [15:0]       hdr_seq;
    logic [15:0]       hdr_len;
    logic              hdr_ok;
    logic              hdr_ts;
    logic [5:0]        hdr_lines;
    logic [16:0]       hdr_min;
    logic [16:0]       hdr_exp_lines;
    logic              hdr_short;
    logic [H-1:0]      item0_lo;
    logic [ITEM_W-1:0] exp_item;
    logic [7:0]        rem_b;
    logic [7:0]        n_items;
    logic              pat_miss;
    logic              pkt_inc, line_inc, pat_err, len_err, seq_err;

    assign beat = s_axis_tvalid & tready_q;

    // Header field decode; only meaningful while state_q == S_HDR.
    always_comb begin
        hdr_type      = s_axis_tdata[55:53];
        hdr_nmd       = s_axis_tdata[52:48];
        hdr_seq       = s_axis_tdata[47:32];
        hdr_len       = s_axis_tdata[31:16];
        hdr_ok        = enable && (hdr_type == 3'd6 || hdr_type == 3'd7);
        // Only a 64-bit bus carries the timestamp on its own line.
        hdr_ts        = (hdr_type == 3'd7) && (CHDR_W == 64);
        hdr_lines     = {1'b0, hdr_nmd} + {5'd0, hdr_ts} + 6'd1;
        hdr_min       = {11'd0, hdr_lines} << LB;
        hdr_exp_lines = ({1'b0, hdr_len} + 17'(BYTES - 1)) >> LB;
        hdr_short     = {1'b0, hdr_len} < hdr_min;
    end

    // Payload pattern check. On the final line only the items covered by
    // Length are compared; a zero remainder means the line is full.
    always_comb begin
        item0_lo = s_axis_tdata[H-1:0];
        exp_item = {~exp_q, exp_q};
        rem_b    = 8'(len_rem_q);
        n_items  = (rem_b == 8'd0) ? 8'(NIPC)
                                   : (rem_b + 8'(IBYTES - 1)) / 8'(IBYTES);
        pat_miss = 1'b0;
        for (int k = 0; k < NIPC; k++) begin
            if ((!s_axis_tlast || (8'(k) < n_items)) &&
                (s_axis_tdata[k*ITEM_W +: ITEM_W] != exp_item)) begin
                pat_miss = 1'b1;
            end
        end
    end

    // Next-state and event logic.
    always_comb begin
        state_d     = state_q;
        len_rem_d   = len_rem_q;
        exp_lines_d = exp_lines_q;
        short_d     = short_q;
        md_left_d   = md_left_q;
        line_no_d   = line_no_q;
        seq_prev_d  = seq_prev_q;
        seq_valid_d = seq_valid_q;
        exp_d       = exp_q;
        locked_d    = locked_q;
        pkt_inc     = 1'b0;
        line_inc    = 1'b0;
        pat_err     = 1'b0;
        len_err     = 1'b0;
        seq_err     = 1'b0;

        if (beat) begin
            case (state_q)
                S_HDR: begin
                    if (!hdr_ok) begin
                        state_d = S_DROP;
                    end else begin
                        len_rem_d   = hdr_len[LB-1:0];
                        exp_lines_d = hdr_exp_lines;
                        short_d     = hdr_short;
                        md_left_d   = hdr_nmd;
                        line_no_d   = 17'd1;
                        if (seq_valid_q && (hdr_seq != seq_prev_q + 16'd1)) begin
                            seq_err = 1'b1;
                        end
                        seq_valid_d = 1'b1;
                        seq_prev_d  = hdr_seq;
                        if (hdr_ts)              state_d = S_TS;
                        else if (hdr_nmd != 5'd0) state_d = S_MD;
                        else                     state_d = S_PYLD;
                        // Header-only packet: it ends on this line.
                        if (s_axis_tlast) begin
                            pkt_inc = 1'b1;
                            len_err = hdr_short || (hdr_exp_lines != 17'd1);
                        end
                    end
                end
                S_TS: begin
                    line_no_d = line_no_q + 17'd1;
                    state_d   = (md_left_q != 5'd0) ? S_MD : S_PYLD;
                end
                S_MD: begin
                    line_no_d = line_no_q + 17'd1;
                    md_left_d = md_left_q - 5'd1;
                    if (md_left_q == 5'd1) state_d = S_PYLD;
                end
                S_PYLD: begin
                    line_no_d = line_no_q + 17'd1;
                    line_inc  = 1'b1;
                    if (!locked_q) begin
                        exp_d    = item0_lo + H_ONE;
                        locked_d = 1'b1;
                    end else if (pat_miss) begin
                        // Resync on the received index so one bad line
                        // does not cascade into every following line.
                        pat_err = 1'b1;
                        exp_d   = item0_lo + H_ONE;
                    end else begin
                        exp_d = exp_q + H_ONE;
                    end
                end
                default: ;  // S_DROP discards everything
            endcase

            if (s_axis_tlast) begin
                state_d = S_HDR;
                if (state_q == S_TS || state_q == S_MD || state_q == S_PYLD) begin
                    pkt_inc = 1'b1;
                    len_err = short_q || ((line_no_q + 17'd1) != exp_lines_q);
                end
            end
        end

        pkt_cnt_d  = pkt_inc  ? pkt_cnt_q  + 32'd1 : pkt_cnt_q;
        line_cnt_d = line_inc ? line_cnt_q + 32'd1 : line_cnt_q;
        pat_cnt_d  = (pat_err && pat_cnt_q != ERR_MAX) ? pat_cnt_q + ERR_ONE : pat_cnt_q;
        len_cnt_d  = (len_err && len_cnt_q != ERR_MAX) ? len_cnt_q + ERR_ONE : len_cnt_q;
        seq_cnt_d  = (seq_err && seq_cnt_q != ERR_MAX) ? seq_cnt_q + ERR_ONE : seq_cnt_q;
        err_stb_d  = pat_err | len_err | seq_err;

        // Clear wins over any same-cycle update; parser position is kept.
        if (clear) begin
            pkt_cnt_d   = '0;
            line_cnt_d  = '0;
            pat_cnt_d   = '0;
            len_cnt_d   = '0;
            seq_cnt_d   = '0;
            err_stb_d   = 1'b0;
            locked_d    = 1'b0;
            seq_valid_d = 1'b0;
        end
    end

    always_ff @(posedge rfnoc_chdr_clk or negedge rfnoc_chdr_rst_n) begin
        if (!rfnoc_chdr_rst_n) begin
            state_q     <= S_HDR;
            len_rem_q   <= '0;
            exp_lines_q <= '0;
            short_q     <= 1'b0;
            md_left_q   <= '0;
            line_no_q   <= '0;
            seq_prev_q  <= '0;
            seq_valid_q <= 1'b0;
            exp_q       <= '0;
            locked_q    <= 1'b0;
            tready_q    <= 1'b0;
            pkt_cnt_q   <= '0;
            line_cnt_q  <= '0;
            pat_cnt_q   <= '0;
            len_cnt_q   <= '0;
            seq_cnt_q   <= '0;
            err_stb_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_rem_q   <= len_rem_d;
            exp_lines_q <= exp_lines_d;
            short_q     <= short_d;
            md_left_q   <= md_left_d;
            line_no_q   <= line_no_d;
            seq_prev_q  <= seq_prev_d;
            seq_valid_q <= seq_valid_d;
            exp_q       <= exp_d;
            locked_q    <= locked_d;
            tready_q    <= 1'b1;
            pkt_cnt_q   <= pkt_cnt_d;
            line_cnt_q  <= line_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
            len_cnt_q   <= len_cnt_d;
            seq_cnt_q   <= seq_cnt_d;
            err_stb_q   <= err_stb_d;
        end
    end

    assign s_axis_tready   = tready_q;
    assign pkt_cnt         = pkt_cnt_q;
    assign line_cnt        = line_cnt_q;
    assign pattern_err_cnt = pat_cnt_q;
    assign len_err_cnt     = len_cnt_q;
    assign seq_err_cnt     = seq_cnt_q;
    assign err_stb         = err_stb_q;
    assign locked          = locked_q;
    assign dbg_state_o     = state_q;

endmodule
